// File: rtl/nebula_mem_arbiter.sv
// Two-client (I-cache / D-cache) line arbiter onto the single bridge line port.
// Round-robin grant, one transaction outstanding, all outputs registered.
module nebula_mem_arbiter #(
  parameter int PADDR_WIDTH = 56
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ic_req,
  input  logic [PADDR_WIDTH-1:0] ic_addr,
  output logic                   ic_ack,
  output logic [511:0]           ic_rdata,
  input  logic                   dc_req,
  input  logic                   dc_we,
  input  logic [PADDR_WIDTH-1:0] dc_addr,
  input  logic [511:0]           dc_wdata,
  output logic                   dc_ack,
  output logic [511:0]           dc_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [PADDR_WIDTH-1:0] mem_addr,
  output logic [511:0]           mem_wdata,
  input  logic                   mem_ack,
  input  logic [511:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

  localparam logic [PADDR_WIDTH-1:0] LINE_MASK = PADDR_WIDTH'(63);

  state_t state, state_nxt;
  logic   last_dc;   // 0 = I-cache granted last, 1 = D-cache
  logic   grant_dc;
  logic   pick_dc;
  logic   latch;
  logic   capture;
  logic [PADDR_WIDTH-1:0] sel_addr;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    capture   = 1'b0;
    // On a tie the client that was not served last wins.
    pick_dc   = dc_req & (~ic_req | ~last_dc);
    sel_addr  = pick_dc ? dc_addr : ic_addr;
    case (state)
      IDLE: begin
        if (ic_req | dc_req) begin
          state_nxt = ISSUE;
          latch     = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mem_ack) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command registers hold until the next grant so the bridge sees a stable
  // command for the whole transfer, including the cycle after mem_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dc   <= 1'b0;
      grant_dc  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      mem_req <= latch;
      ic_ack  <= capture & ~grant_dc;
      dc_ack  <= capture & grant_dc;
      if (latch) begin
        grant_dc  <= pick_dc;
        mem_addr  <= sel_addr & ~LINE_MASK;
        mem_we    <= pick_dc & dc_we;
        mem_wdata <= pick_dc ? dc_wdata : '0;
      end
      if (capture) begin
        last_dc <= grant_dc;
        if (!grant_dc)    ic_rdata <= mem_rdata;
        else if (!mem_we) dc_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_nebula_mem_arbiter.sv
// Randomized scoreboard bench for nebula_mem_arbiter with a bridge model.
module tb_nebula_mem_arbiter;
  localparam int AW = 56;
  localparam logic [AW-1:0] MASK = AW'(63);
  typedef logic [511:0] line_t;
  typedef struct { bit dc; bit we; logic [AW-1:0] addr; line_t wdata; } cmd_t;
  typedef struct { bit dc; bit rd; line_t data; int cyc; } rsp_t;

  logic clk = 0, rst_n = 0;
  logic ic_req = 0, dc_req = 0, dc_we = 0, mem_ack = 0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  line_t dc_wdata = '0, mem_rdata = '0;
  logic ic_ack, dc_ack, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  line_t ic_rdata, dc_rdata, mem_wdata;

  nebula_mem_arbiter #(.PADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int req_cycles[$];
  cmd_t cur;
  bit out_pending = 0, real_ack = 0, spur_req = 0, hold = 0;
  int lat = 0, force_lat = -1;
  bit m_last = 0;          // model: 0 = ic granted last, 1 = dc
  line_t m_ic = '0, m_dc = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[AW-1:0];
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ic_ack"},    ic_ack,    0);
    chk({tag, "_dc_ack"},    dc_ack,    0);
    chk({tag, "_mem_req"},   mem_req,   0);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_ic_rdata"},  ic_rdata,  0);
    chk({tag, "_dc_rdata"},  dc_rdata,  0);
  endtask

  // Command monitor: every launch must match the next expected command.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        req_cycles.push_back(cyc);
        chk("mem_req_while_outstanding", out_pending, 0);
        chk("mem_req_expected", exp_cmd.size() != 0, 1);
        if (exp_cmd.size() != 0) begin
          cur = exp_cmd.pop_front();
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_we", mem_we, cur.we);
          chk("mem_wdata", mem_wdata, cur.wdata);
          out_pending = 1;
          lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
        end
      end else if (out_pending || real_ack) begin
        chk("hold_mem_addr", mem_addr, cur.addr);
        chk("hold_mem_we", mem_we, cur.we);
        chk("hold_mem_wdata", mem_wdata, cur.wdata);
      end
    end
  end

  // Bridge model.
  initial begin
    line_t d;
    forever begin
      @(posedge clk); #1;
      mem_ack = 0;
      real_ack = 0;
      if (spur_req) begin
        mem_ack = 1;
        mem_rdata = rand_line();
        spur_req = 0;
      end else if (out_pending && !hold) begin
        if (lat == 0) begin
          d = rand_line();
          mem_ack = 1;
          real_ack = 1;
          mem_rdata = d;
          exp_rsp.push_back('{dc: cur.dc, rd: !cur.we, data: d, cyc: cyc + 1});
          out_pending = 0;
        end else lat--;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t r;
    if (rst_n && (ic_ack || dc_ack)) begin
      chk("ack_expected", exp_rsp.size() != 0, 1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        chk("ack_cycle", cyc, r.cyc);
        chk("ic_ack", ic_ack, !r.dc);
        chk("dc_ack", dc_ack, r.dc);
        if (r.rd) begin
          if (r.dc) m_dc = r.data;
          else      m_ic = r.data;
        end
        chk("ic_rdata", ic_rdata, m_ic);
        chk("dc_rdata", dc_rdata, m_dc);
      end
    end
  end

  // Presents one or both requests together and serves them to completion.
  task automatic run_round(input bit u_ic, input bit u_dc, input bit we,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input line_t wd, input bit chk_lat);
    cmd_t ci, cd;
    int left, budget, start;
    bit aic, adc;
    ci = '{dc: 0, we: 0, addr: ia & ~MASK, wdata: '0};
    cd = '{dc: 1, we: we, addr: da & ~MASK, wdata: wd};
    if (u_ic && u_dc) begin
      if (!m_last) begin exp_cmd.push_back(cd); exp_cmd.push_back(ci); m_last = 0; end
      else         begin exp_cmd.push_back(ci); exp_cmd.push_back(cd); m_last = 1; end
    end else if (u_ic) begin
      exp_cmd.push_back(ci); m_last = 0;
    end else if (u_dc) begin
      exp_cmd.push_back(cd); m_last = 1;
    end
    req_cycles.delete();
    start = cyc;
    ic_addr = ia; dc_addr = da; dc_we = we; dc_wdata = wd;
    ic_req = u_ic; dc_req = u_dc;
    left = int'(u_ic) + int'(u_dc);
    budget = 400;
    while (left > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      aic = ic_ack; adc = dc_ack;
      @(posedge clk); #1;
      if (aic && ic_req) begin ic_req = 0; left--; end
      if (adc && dc_req) begin dc_req = 0; left--; end
    end
    chk("round_complete", left, 0);
    ic_req = 0; dc_req = 0;
    if (chk_lat) chk("req_latency", (req_cycles.size() != 0) ? req_cycles[0] - start : -1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;
    logic [AW-1:0] x;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk_zero_outs("reset");
    @(posedge clk); #1;

    // I-cache refill from idle, offset bits cleared.
    repeat (2) @(posedge clk); #1;
    run_round(1, 0, 0, 56'h1000_0027, '0, '0, 1);
    // D-cache refill, then a slow writeback that must leave dc_rdata alone.
    repeat (2) @(posedge clk); #1;
    run_round(0, 1, 0, '0, rand_addr(), rand_line(), 1);
    force_lat = 40;
    run_round(0, 1, 1, '0, 56'h2000_0040, rand_line(), 0);
    force_lat = -1;
    // Ties alternate.
    run_round(1, 1, 0, rand_addr(), rand_addr(), rand_line(), 0);
    run_round(1, 1, 1, rand_addr(), rand_addr(), rand_line(), 0);

    for (int n = 0; n < 30; n++) begin
      bit a, b;
      idle = $urandom_range(0, 3);
      repeat (idle) @(posedge clk);
      #0;
      a = $urandom_range(0, 1);
      b = a ? 1'($urandom_range(0, 1)) : 1'b1;
      run_round(a, b, 1'($urandom_range(0, 1)), rand_addr(), rand_addr(), rand_line(), idle == 3);
    end

    // Spurious bridge ack while idle must not produce a client ack.
    repeat (2) @(posedge clk); #1;
    spur_req = 1;
    repeat (3) @(posedge clk); #1;
    run_round(1, 0, 0, rand_addr(), '0, '0, 1);

    // Reset in the middle of a transaction.
    repeat (2) @(posedge clk); #1;
    hold = 1;
    x = rand_addr();
    exp_cmd.push_back('{dc: 1, we: 0, addr: x & ~MASK, wdata: '0});
    dc_we = 0; dc_addr = x; dc_wdata = '0; dc_req = 1;
    repeat (6) @(posedge clk);
    #3;
    chk("wait_before_reset", out_pending, 1);
    rst_n = 0;
    #1;
    chk_zero_outs("async_reset");
    dc_req = 0; out_pending = 0; hold = 0;
    exp_cmd.delete(); exp_rsp.delete();
    m_ic = '0; m_dc = '0; m_last = 0;
    @(posedge clk); #1;
    rst_n = 1;
    spur_req = 1;
    repeat (3) @(posedge clk); #1;
    run_round(0, 1, 0, '0, rand_addr(), rand_line(), 1);
    run_round(1, 1, 0, rand_addr(), rand_addr(), rand_line(), 0);

    repeat (4) @(posedge clk);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
